serial_add_sequencer: RTL

- Bit-serial adder/subtractor controller. One full-adder bit cell, built from two halfAdder instances plus an OR, is sequenced over WIDTH cycles to produce a WIDTH-bit sum or difference.
- Sits beside the ALU as an area-minimal arithmetic unit for non-critical datapaths.
- Uses a start/ready/done handshake and provides carry, overflow and zero flags.

---
 rtl/arith_defs.sv | 12 +
 rtl/half_adder.sv | 12 +
 rtl/serial_fa_cell.sv | 30 +++
 rtl/serial_add_sequencer.sv | 125 ++++++++++++
 4 files changed

// File: rtl/arith_defs.sv
// rtl/arith_defs.sv - FSM state encodings and counter sizing for the serial adder
package arith_defs;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/half_adder.sv
// rtl/half_adder.sv - 1-bit half adder
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/serial_fa_cell.sv
// rtl/serial_fa_cell.sv - combinational 1-bit full adder built from two half adders
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .x (a),
        .y (b),
        .s (s0),
        .c (c0)
    );

    half_adder u_ha1 (
        .x (s0),
        .y (cin),
        .s (s),
        .c (c1)
    );

    assign cout = c0 | c1;

endmodule

// File: rtl/serial_add_sequencer.sv
// rtl/serial_add_sequencer.sv - bit-serial add/subtract sequencer with start/ready/done handshake
module serial_add_sequencer
    import arith_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] op_a_q,    op_a_d;
    logic [WIDTH-1:0] op_b_q,    op_b_d;
    logic [WIDTH-1:0] res_q,     res_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic             c_q,       c_d;
    logic             carry_q,   carry_d;
    logic             ovf_q,     ovf_d;
    logic             zero_q,    zero_d;

    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH-1:0] res_shift;

    serial_fa_cell u_cell (
        .a    (op_a_q[0]),
        .b    (op_b_q[0]),
        .cin  (c_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // LSB-first: each new sum bit enters at the MSB so the word is aligned after WIDTH shifts
    assign res_shift = {fa_s, res_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_a_d  = a;
                    op_b_d  = sub ? ~b : b;
                    c_d     = sub;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d  = res_shift;
                op_a_d = op_a_q >> 1;
                op_b_d = op_b_q >> 1;
                c_d    = fa_cout;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    carry_d = fa_cout;
                    ovf_d   = c_q ^ fa_cout;
                    zero_d  = (res_shift == '0);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign ready     = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign result    = res_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule
